mem_wb: RTL and testbench

- MEM/WB pipeline register of the 5-stage CPU.
- Captures memory-stage results and write-back control at each rising clock edge.
- Presents them to the write-back stage for one full cycle.
- No stall or enable: the register loads every cycle unless in reset.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/pipe_reg.sv | 26 ++
 rtl/mem_wb.sv | 57 +++++
 tb/tb_mem_wb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths and the write-back control bundle
// carried by the ID/EX, EX/MEM and MEM/WB registers.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
  } wb_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register, 1-cycle latency, synchronous active-high clear to 0.
// Loads every cycle; no stall, no backpressure.
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = d;
    if (rst) q_d = '0;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: 1-cycle latency, loads every edge, no backpressure.
// MEM_WB_WBMUX_EN adds the write-back source mux as output wb_data.
module mem_wb #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [DATA_W-1:0] D_MEM_read_data_in,
  input  logic [DATA_W-1:0] D_MEM_read_addr_in,
  input  logic [REG_W-1:0]  EX_MEM_RegisterRd_in,
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] D_MEM_read_data_out,
  output logic [DATA_W-1:0] D_MEM_read_addr_out,
  output logic [REG_W-1:0]  MEM_WB_RegisterRd_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out
`ifdef MEM_WB_WBMUX_EN
  ,
  output logic [DATA_W-1:0] wb_data
`endif
);

  import cpu_pkg::*;

  localparam int BUS_W = 2 * DATA_W + REG_W + $bits(wb_ctrl_t);

  wb_ctrl_t         ctrl_in;
  wb_ctrl_t         ctrl_out;
  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] bus_out;

  assign ctrl_in.RegWrite = RegWrite_in;
  assign ctrl_in.MemtoReg = MemtoReg_in;

  assign bus_in = {ctrl_in, EX_MEM_RegisterRd_in, D_MEM_read_addr_in, D_MEM_read_data_in};

  // Single register over the whole bundle keeps all fields aligned to the same edge.
  pipe_reg #(
    .WIDTH(BUS_W)
  ) u_bus_reg (
    .clk(clk),
    .rst(rst),
    .d  (bus_in),
    .q  (bus_out)
  );

  assign {ctrl_out, MEM_WB_RegisterRd_out, D_MEM_read_addr_out, D_MEM_read_data_out} = bus_out;
  assign RegWrite_out = ctrl_out.RegWrite;
  assign MemtoReg_out = ctrl_out.MemtoReg;

`ifdef MEM_WB_WBMUX_EN
  assign wb_data = MemtoReg_out ? D_MEM_read_data_out : D_MEM_read_addr_out;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: reset, capture, pipelining, mid-stream reset,
// between-edge immunity, and a short seeded run against a 1-cycle-delay model.
module tb_mem_wb;

  logic        clk;
  logic        rst;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [31:0] data_in;
  logic [31:0] addr_in;
  logic [4:0]  rd_in;
  logic [31:0] data_out;
  logic [31:0] addr_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_to_reg_out;
`ifdef MEM_WB_WBMUX_EN
  logic [31:0] wb_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_wb dut (
    .RegWrite_in          (reg_write_in),
    .MemtoReg_in          (mem_to_reg_in),
    .D_MEM_read_data_in   (data_in),
    .D_MEM_read_addr_in   (addr_in),
    .EX_MEM_RegisterRd_in (rd_in),
    .clk                  (clk),
    .rst                  (rst),
    .D_MEM_read_data_out  (data_out),
    .D_MEM_read_addr_out  (addr_out),
    .MEM_WB_RegisterRd_out(rd_out),
    .RegWrite_out         (reg_write_out),
    .MemtoReg_out         (mem_to_reg_out)
`ifdef MEM_WB_WBMUX_EN
    ,
    .wb_data              (wb_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against an expected set of registered values.
  task automatic chk_all(input string tag, input logic rw, input logic m2r,
                         input logic [31:0] d, input logic [31:0] a, input logic [4:0] r);
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".addr"}, addr_out, a);
    chk({tag, ".rd"}, {27'd0, rd_out}, {27'd0, r});
    chk({tag, ".regwrite"}, {31'd0, reg_write_out}, {31'd0, rw});
    chk({tag, ".memtoreg"}, {31'd0, mem_to_reg_out}, {31'd0, m2r});
`ifdef MEM_WB_WBMUX_EN
    chk({tag, ".wb_data"}, wb_data, m2r ? d : a);
`endif
  endtask

  task automatic drive(input logic r, input logic rw, input logic m2r,
                       input logic [31:0] d, input logic [31:0] a, input logic [4:0] rd);
    rst           = r;
    reg_write_in  = rw;
    mem_to_reg_in = m2r;
    data_in       = d;
    addr_in       = a;
    rd_in         = rd;
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        m_rst, m_rw, m_m2r;
    logic [31:0] m_d, m_a;
    logic [4:0]  m_rd;

    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
    tick();
    chk_all("reset", 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);

    // Capture: nothing visible until the edge.
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1000, 5'd17);
    #2;
    chk_all("capture_pre", 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    tick();
    chk_all("capture", 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1000, 5'd17);

    // Pipelining through A, B, C.
    drive(1'b0, 1'b0, 1'b0, 32'hAAAA_0001, 32'h0000_0A0A, 5'd1);
    tick();
    chk_all("pipe_a", 1'b0, 1'b0, 32'hAAAA_0001, 32'h0000_0A0A, 5'd1);
    drive(1'b0, 1'b1, 1'b0, 32'hBBBB_0002, 32'h8000_0000, 5'd0);
    tick();
    chk_all("pipe_b_rd0", 1'b1, 1'b0, 32'hBBBB_0002, 32'h8000_0000, 5'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hCCCC_0003, 32'hFFFF_FFFE, 5'd31);
    tick();
    chk_all("pipe_c", 1'b0, 1'b1, 32'hCCCC_0003, 32'hFFFF_FFFE, 5'd31);

    // Mid-stream reset discards the in-flight value.
    drive(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_0040, 5'd9);
    tick();
    chk_all("mid_load", 1'b1, 1'b1, 32'h1234_5678, 32'h0000_0040, 5'd9);
    drive(1'b1, 1'b1, 1'b1, 32'h9ABC_DEF0, 32'h0000_0044, 5'd10);
    tick();
    chk_all("mid_rst", 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    rst = 1'b0;
    tick();
    chk_all("mid_after", 1'b1, 1'b1, 32'h9ABC_DEF0, 32'h0000_0044, 5'd10);

    // Between-edge reset pulse and input glitches must not disturb outputs.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h5555_5555, 32'h6666_6666, 5'd3);
    #1;
    drive(1'b0, 1'b1, 1'b0, 32'h0F0F_0F0F, 32'h7070_7070, 5'd22);
    #1;
    chk_all("glitch_hold", 1'b1, 1'b1, 32'h9ABC_DEF0, 32'h0000_0044, 5'd10);
    tick();
    chk_all("glitch_edge", 1'b1, 1'b0, 32'h0F0F_0F0F, 32'h7070_7070, 5'd22);

    // Reset held for three edges.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst_hold", 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    end

    // Seeded run against a 1-cycle-delay reference.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
            $urandom, $urandom, 5'($urandom));
      m_rst = rst;
      m_rw  = reg_write_in;
      m_m2r = mem_to_reg_in;
      m_d   = data_in;
      m_a   = addr_in;
      m_rd  = rd_in;
      tick();
      if (m_rst) chk_all("rand_rst", 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
      else       chk_all("rand", m_rw, m_m2r, m_d, m_a, m_rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
